// File: rtl/t05_sram_pkg.sv
// Shared types and constants for the multi-client SRAM access engine.
package t05_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          BUS_W   = 32;
  localparam logic [3:0]  SEL_ALL = 4'hF;

  localparam int CH_HIST  = 0;
  localparam int CH_FLV   = 1;
  localparam int CH_HTREE = 2;
  localparam int CH_CB    = 3;
  localparam int CH_TRN   = 4;

endpackage

// File: rtl/t05_sram_rr_arb.sv
// Client arbiter: round-robin when T05_SRAM_RR_EN is defined, otherwise fixed
// priority with the lowest channel index winning.
module t05_sram_rr_arb #(
  parameter int NUM_CH = 5,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
`ifdef T05_SRAM_RR_EN
  input  logic              clk,
  input  logic              nrst,
`endif
  input  logic              i_en,
  input  logic [NUM_CH-1:0] i_req,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [IDX_W-1:0]  o_idx
);

  logic [IDX_W-1:0] w_win;

`ifdef T05_SRAM_RR_EN
  logic [IDX_W-1:0] r_ptr;
`endif

  // Winner is the requester with the smallest distance from the search start.
  always_comb begin
    int v_rank;
    int v_best;
    v_best = NUM_CH;
    v_rank = 0;
    w_win  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
`ifdef T05_SRAM_RR_EN
      v_rank = (c >= int'(r_ptr)) ? (c - int'(r_ptr)) : (c + NUM_CH - int'(r_ptr));
`else
      v_rank = c;
`endif
      if (i_req[c] && (v_rank < v_best)) begin
        v_best = v_rank;
        w_win  = IDX_W'(c);
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      o_gnt[c] = i_en && i_req[c] && (w_win == IDX_W'(c));
    end
  end

  assign o_idx = w_win;

`ifdef T05_SRAM_RR_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ptr <= '0;
    end else if (i_en && (|i_req)) begin
      r_ptr <= (w_win == IDX_W'(NUM_CH - 1)) ? '0 : (w_win + IDX_W'(1));
    end
  end
`endif

endmodule

// File: rtl/t05_sram_arbiter.sv
// Multi-client SRAM access engine: arbitrates, splits payloads into 32-bit beats
// and assembles read data. Define T05_SRAM_RR_EN for round-robin arbitration.
module t05_sram_arbiter
  import t05_sram_pkg::*;
#(
  parameter int NUM_CH    = 5,
  parameter int MAX_WORDS = 4,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 3
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [NUM_CH-1:0]             req_i,
  input  logic [NUM_CH-1:0]             we_i,
  input  logic [NUM_CH*ADDR_W-1:0]      addr_i,
  input  logic [NUM_CH*CNT_W-1:0]       nwords_i,
  input  logic [NUM_CH*32*MAX_WORDS-1:0] wdata_i,
  output logic [NUM_CH-1:0]             gnt_o,
  output logic [NUM_CH-1:0]             done_o,
  output logic [32*MAX_WORDS-1:0]       rdata_o,
  output logic [31:0]                   bus_addr_o,
  output logic [31:0]                   bus_wdata_o,
  input  logic [31:0]                   bus_rdata_i,
  output logic                          bus_wen_o,
  output logic                          bus_ren_o,
  output logic [3:0]                    bus_sel_o,
  input  logic                          bus_busy_i
);

  localparam int PAYLOAD_W = BUS_W * MAX_WORDS;
  localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t                 r_state;
  logic                   r_we;
  logic [CNT_W-1:0]       r_nwords;
  logic [CNT_W-1:0]       r_beat;
  logic [NUM_CH-1:0]      r_ch_oh;
  logic [ADDR_W-1:0]      r_addr;
  logic [PAYLOAD_W-1:0]   r_wdata;

  logic [NUM_CH-1:0]      w_gnt;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_any;
  logic                   w_arb_en;
  logic                   w_sel_we;
  logic [ADDR_W-1:0]      w_sel_addr;
  logic [CNT_W-1:0]       w_sel_nw;
  logic [CNT_W-1:0]       w_nw_clamped;
  logic [PAYLOAD_W-1:0]   w_sel_wdata;
  logic [ADDR_W-1:0]      w_next_addr;
  logic                   w_grant;
  logic                   w_beat_done;

  function automatic logic [CNT_W-1:0] clamp_nw(input logic [CNT_W-1:0] n);
    if (n > CNT_W'(MAX_WORDS)) begin
      return CNT_W'(MAX_WORDS);
    end
    return n;
  endfunction

  assign w_any       = |req_i;
  assign w_arb_en    = (r_state == IDLE);
  assign w_grant     = (r_state == IDLE) && w_any;
  assign w_beat_done = (r_state == WAIT) && !bus_busy_i;
  assign w_next_addr = r_addr + ADDR_W'(4);

  t05_sram_rr_arb #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
`ifdef T05_SRAM_RR_EN
    .clk    (clk),
    .nrst   (nrst),
`endif
    .i_en   (w_arb_en),
    .i_req  (req_i),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx)
  );

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_nw    = '0;
    w_sel_wdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_idx == IDX_W'(c)) begin
        w_sel_we    = we_i[c];
        w_sel_addr  = addr_i[c*ADDR_W +: ADDR_W];
        w_sel_nw    = nwords_i[c*CNT_W +: CNT_W];
        w_sel_wdata = wdata_i[c*PAYLOAD_W +: PAYLOAD_W];
      end
    end
    w_nw_clamped = clamp_nw(w_sel_nw);
  end

  // Beat address and write payload advance together; bit 0 of r_wdata is always the next beat.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata >> BUS_W;
    end else if (w_beat_done) begin
      r_addr  <= w_next_addr;
      r_wdata <= r_wdata >> BUS_W;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_nwords    <= '0;
      r_beat      <= '0;
      r_ch_oh     <= '0;
      gnt_o       <= '0;
      done_o      <= '0;
      rdata_o     <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wen_o   <= 1'b0;
      bus_ren_o   <= 1'b0;
      bus_sel_o   <= '0;
    end else begin
      gnt_o     <= '0;
      done_o    <= '0;
      bus_wen_o <= 1'b0;
      bus_ren_o <= 1'b0;
      bus_sel_o <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            gnt_o    <= w_gnt;
            r_ch_oh  <= w_gnt;
            r_we     <= w_sel_we;
            r_nwords <= w_nw_clamped;
            r_beat   <= '0;
            if (!w_sel_we) begin
              rdata_o <= '0;
            end
            if (w_nw_clamped == '0) begin
              r_state <= DONE;
            end else begin
              // Strobe rises with the move into ISSUE so it is high for exactly that cycle.
              r_state     <= ISSUE;
              bus_addr_o  <= BUS_W'(w_sel_addr);
              bus_wdata_o <= w_sel_wdata[BUS_W-1:0];
              bus_wen_o   <= w_sel_we;
              bus_ren_o   <= !w_sel_we;
              bus_sel_o   <= SEL_ALL;
            end
          end
        end
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (!bus_busy_i) begin
            if (!r_we) begin
              for (int k = 0; k < MAX_WORDS; k++) begin
                if (r_beat == CNT_W'(k)) begin
                  rdata_o[k*BUS_W +: BUS_W] <= bus_rdata_i;
                end
              end
            end
            if (r_beat == (r_nwords - CNT_W'(1))) begin
              r_state <= DONE;
            end else begin
              r_beat      <= r_beat + CNT_W'(1);
              r_state     <= ISSUE;
              bus_addr_o  <= BUS_W'(w_next_addr);
              bus_wdata_o <= r_wdata[BUS_W-1:0];
              bus_wen_o   <= r_we;
              bus_ren_o   <= !r_we;
              bus_sel_o   <= SEL_ALL;
            end
          end
        end
        DONE: begin
          done_o  <= r_ch_oh;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// Directed bench for t05_sram_arbiter with a bus-beat scoreboard and an SRAM responder.
module tb_t05_sram_arbiter;

  localparam int NUM_CH = 5;
  localparam int MAXW   = 4;
  localparam int CNT_W  = 3;
  localparam int PW     = 32 * MAXW;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  logic                      clk = 1'b0;
  logic                      nrst = 1'b0;
  logic [NUM_CH-1:0]         req_i = '0;
  logic [NUM_CH-1:0]         we_i = '0;
  logic [NUM_CH*32-1:0]      addr_i = '0;
  logic [NUM_CH*CNT_W-1:0]   nwords_i = '0;
  logic [NUM_CH*PW-1:0]      wdata_i = '0;
  logic [NUM_CH-1:0]         gnt_o;
  logic [NUM_CH-1:0]         done_o;
  logic [PW-1:0]             rdata_o;
  logic [31:0]               bus_addr_o;
  logic [31:0]               bus_wdata_o;
  logic [31:0]               bus_rdata_i = '0;
  logic                      bus_wen_o;
  logic                      bus_ren_o;
  logic [3:0]                bus_sel_o;
  logic                      bus_busy_i = 1'b0;

  int    total = 0;
  int    bad   = 0;
  int    busy_len = 0;
  int    busy_cnt = 0;
  beat_t exp_q[$];
  beat_t mon_e;

  t05_sram_arbiter #(
    .NUM_CH(NUM_CH), .MAX_WORDS(MAXW), .ADDR_W(32), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .nrst(nrst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .nwords_i(nwords_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .done_o(done_o),
    .rdata_o(rdata_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_wen_o(bus_wen_o), .bus_ren_o(bus_ren_o),
    .bus_sel_o(bus_sel_o), .bus_busy_i(bus_busy_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    case (a)
      32'h100: return 32'h2C;
      32'h104: return 32'h4C;
      default: return a ^ 32'hC0DE_1234;
    endcase
  endfunction

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SRAM responder: busy for busy_len cycles after each strobe, read data by address.
  always @(posedge clk) begin
    if (bus_ren_o || bus_wen_o) begin
      busy_cnt    <= busy_len;
      bus_busy_i  <= (busy_len != 0);
      bus_rdata_i <= rd_model(bus_addr_o);
    end else if (busy_cnt > 1) begin
      busy_cnt   <= busy_cnt - 1;
      bus_busy_i <= 1'b1;
    end else begin
      busy_cnt   <= 0;
      bus_busy_i <= 1'b0;
    end
  end

  // Scoreboard: every strobe must match the next expected beat.
  always @(negedge clk) begin
    if (nrst && (bus_wen_o || bus_ren_o)) begin
      if (exp_q.size() == 0) begin
        check("bus_extra_strobe", PW'({bus_wen_o, bus_ren_o}), '0);
      end else begin
        mon_e = exp_q.pop_front();
        check("bus_addr", PW'(bus_addr_o), PW'(mon_e.addr));
        check("bus_dir", PW'({bus_wen_o, bus_ren_o}), PW'({mon_e.wen, !mon_e.wen}));
        check("bus_sel", PW'(bus_sel_o), PW'(4'hF));
        if (mon_e.wen) check("bus_wdata", PW'(bus_wdata_o), PW'(mon_e.wdata));
      end
    end
  end

  task automatic set_ch(input int ch, input logic we, input logic [31:0] a,
                        input logic [CNT_W-1:0] nw, input logic [PW-1:0] wd);
    we_i[ch]                  = we;
    addr_i[ch*32 +: 32]       = a;
    nwords_i[ch*CNT_W +: CNT_W] = nw;
    wdata_i[ch*PW +: PW]      = wd;
  endtask

  task automatic push_beats(input logic we, input logic [31:0] a,
                            input logic [CNT_W-1:0] nw, input logic [PW-1:0] wd);
    int n;
    beat_t b;
    n = (int'(nw) > MAXW) ? MAXW : int'(nw);
    for (int k = 0; k < n; k++) begin
      b.wen   = we;
      b.addr  = a + 32'(4 * k);
      b.wdata = wd[k*32 +: 32];
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_pulse(input string tag, input bit is_done,
                            input logic [NUM_CH-1:0] exp, input int budget);
    int n;
    logic [NUM_CH-1:0] v;
    n = 0;
    v = '0;
    while (v == '0 && n < budget) begin
      @(negedge clk);
      v = is_done ? done_o : gnt_o;
      n++;
    end
    check(tag, PW'(v), PW'(exp));
  endtask

  task automatic run_txn(input string tag, input int ch, input logic we,
                         input logic [31:0] a, input logic [CNT_W-1:0] nw,
                         input logic [PW-1:0] wd, input int busy);
    busy_len = busy;
    push_beats(we, a, nw, wd);
    set_ch(ch, we, a, nw, wd);
    req_i[ch] = 1'b1;
    wait_pulse({tag, "_gnt"}, 1'b0, NUM_CH'(1 << ch), 5);
    req_i[ch] = 1'b0;
    wait_pulse({tag, "_done"}, 1'b1, NUM_CH'(1 << ch), 60);
    check({tag, "_beats_left"}, PW'(exp_q.size()), '0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rdata"}, rdata_o, '0);
    check({tag, "_ctl"}, PW'({gnt_o, done_o, bus_addr_o, bus_wdata_o,
                             bus_wen_o, bus_ren_o, bus_sel_o}), '0);
  endtask

  initial begin
    logic [PW-1:0]     exp_rd;
    logic [NUM_CH-1:0] seen;
    logic [NUM_CH-1:0] rr_exp [4];
    int n;

    nrst = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    nrst = 1'b1;
    @(negedge clk);

    // Write ch0: grant, one beat, done three cycles after the grant.
    busy_len = 0;
    push_beats(1'b1, 32'h40, 3'd1, PW'(32'h7));
    set_ch(0, 1'b1, 32'h40, 3'd1, PW'(32'h7));
    req_i[0] = 1'b1;
    wait_pulse("wr_ch0_gnt", 1'b0, 5'b00001, 5);
    req_i[0] = 1'b0;
    @(negedge clk);
    check("wr_ch0_done_early1", PW'(done_o), '0);
    @(negedge clk);
    check("wr_ch0_done_early2", PW'(done_o), '0);
    @(negedge clk);
    check("wr_ch0_done_lat3", PW'(done_o), PW'(5'b00001));
    check("wr_ch0_beats_left", PW'(exp_q.size()), '0);

    // Two-beat read with busy stretching each beat.
    run_txn("rd_ch2", 2, 1'b0, 32'h100, 3'd2, '0, 2);
    check("rd_ch2_rdata", rdata_o, PW'(64'h0000004C_0000002C));

    // Zero-length write: no bus access, rdata untouched.
    run_txn("nw0_ch3", 3, 1'b1, 32'h180, 3'd0, PW'(32'hDEAD), 0);
    check("nw0_rdata_hold", rdata_o, PW'(64'h0000004C_0000002C));

    // Over-long read clamps to four beats.
    run_txn("nw7_ch3", 3, 1'b0, 32'h200, 3'd7, '0, 1);
    for (int k = 0; k < MAXW; k++) exp_rd[k*32 +: 32] = rd_model(32'h200 + 32'(4 * k));
    check("nw7_rdata", rdata_o, exp_rd);

    // Short read clears the upper beats.
    run_txn("rd1_ch3", 3, 1'b0, 32'h300, 3'd1, '0, 0);
    check("rd1_rdata", rdata_o, PW'(rd_model(32'h300)));

    // Address wraps modulo 2^32.
    run_txn("wrap_ch0", 0, 1'b1, 32'hFFFF_FFFC, 3'd2, PW'(64'h00000022_00000011), 0);

    // Request dropped right after grant; all three beats still run.
    run_txn("drop_ch4", 4, 1'b1, 32'h800, 3'd3, PW'(96'h333_00000222_00000111), 1);

    // Reset during WAIT of beat 1 of 4.
    busy_len = 3;
    push_beats(1'b0, 32'h500, 3'd2, '0);
    set_ch(1, 1'b0, 32'h500, 3'd4, '0);
    req_i[1] = 1'b1;
    wait_pulse("abort_gnt", 1'b0, 5'b00010, 5);
    req_i[1] = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("abort_reach_beat1", PW'(exp_q.size()), '0);
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check_outputs_zero("abort");
    seen = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      seen |= done_o;
    end
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen |= done_o;
    end
    check("abort_no_done", PW'(seen), '0);
    run_txn("restart_ch1", 1, 1'b0, 32'h500, 3'd4, '0, 0);

    // Held multi-channel request from a fresh reset.
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
`ifdef T05_SRAM_RR_EN
    rr_exp[0] = 5'b00010; rr_exp[1] = 5'b00100; rr_exp[2] = 5'b10000; rr_exp[3] = 5'b00010;
`else
    rr_exp[0] = 5'b00010; rr_exp[1] = 5'b00010; rr_exp[2] = 5'b00010; rr_exp[3] = 5'b00010;
`endif
    set_ch(1, 1'b1, 32'h10, 3'd0, '0);
    set_ch(2, 1'b1, 32'h20, 3'd0, '0);
    set_ch(4, 1'b1, 32'h40, 3'd0, '0);
    req_i = 5'b10110;
    for (int g = 0; g < 4; g++) begin
      wait_pulse($sformatf("arb_grant%0d", g), 1'b0, rr_exp[g], 6);
    end
    req_i = '0;
    repeat (4) @(negedge clk);
    check("arb_idle_gnt", PW'(gnt_o), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
